ip_codma_crc_scheduler: RTL and testbench
=========================================

IP_CODMA_CRC_SCHEDULER -- requirements
Module: ip_codma_crc_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of CRC requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, number of WAIT cycles before abort (used only with the timeout feature).
REQ-003 SHALL have port clk_i  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester job request.
REQ-006 SHALL have port req_data_i  input  NUM_REQ x 8x32  per-requester 256-bit data block.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  one-hot accept pulse.
REQ-008 SHALL have port crc_start_o  output  1  engine launch pulse.
REQ-009 SHALL have port crc_data_o  output  8x32  block to engine.
REQ-010 SHALL have port crc_done_i  input  1  engine completion.
REQ-011 SHALL have port crc_result_i  input  16  engine remainder.
REQ-012 SHALL have port rsp_valid_o  output  1  result available.
REQ-013 SHALL have port rsp_ready_i  input  1  result consumed.
REQ-014 SHALL have port rsp_id_o  output  3  index of the served requester.
REQ-015 SHALL have port rsp_crc_o  output  16  CRC result.
REQ-016 SHALL have port rsp_err_o  output  1  job aborted.
REQ-017 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM IDLE -> LAUNCH -> WAIT -> RESPOND -> IDLE.
REQ-019 SHALL, in IDLE with any req_valid_i set, select one requester round-robin starting at the priority pointer, pulse its req_ready_o bit for exactly 1 cycle, latch its req_data_i and index, and enter LAUNCH.
REQ-020 SHALL drive crc_start_o high for exactly 1 cycle in LAUNCH, then enter WAIT.
REQ-021 SHALL hold crc_data_o equal to the latched block from LAUNCH through RESPOND, stable and unchanged.
REQ-022 SHALL sample crc_done_i only in WAIT; on done, capture crc_result_i into rsp_crc_o and enter RESPOND; done in any other state is ignored.
REQ-023 SHALL hold rsp_valid_o high in RESPOND until rsp_ready_i; rsp_id_o, rsp_crc_o and rsp_err_o are stable while valid.
REQ-024 SHALL, on the rsp handshake, move the priority pointer to (served index + 1) mod NUM_REQ and return to IDLE.
REQ-025 SHALL give the minimum request-to-rsp_valid latency as 3 cycles plus engine latency; a back-to-back grant occurs no earlier than 1 cycle after the handshake.
REQ-026 SHALL accept no new request outside IDLE; requests withdrawn before their grant are not served.
REQ-027 SHALL accept the request when req_valid_i and pointer coincide on the same requester.

Reset
REQ-028 SHALL, on reset_n_i low at any time including mid-job, force IDLE, pointer 0, and all outputs 0 (crc_data_o 0, rsp_* 0, req_ready_o 0, busy_o 0).
REQ-029 SHALL leave the engine's in-flight done/result ignored after reset release.

Configuration
REQ-030 SHALL, with CODMA_CRC_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES without done, enter RESPOND with rsp_err_o=1 and rsp_crc_o=0.
REQ-031 SHALL, without CODMA_CRC_TIMEOUT_EN, wait indefinitely in WAIT, tie rsp_err_o to 0, and include no counter logic.

Structure
REQ-032 SHALL place the FSM state enum (IDLE/LAUNCH/WAIT/RESPOND) and the CRC width constant (16) in the shared ip_codma_machine_states_pkg.
REQ-033 SHALL implement round-robin selection in sub-module ip_codma_rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, index).

Verification
REQ-034 SHALL cover a single request: req_valid_i=4'b0100, data word0=32'h000069f2 -> req_ready_o=4'b0100 for 1 cycle, crc_start_o 1 cycle later, rsp_id_o=2 with engine result.
REQ-035 SHALL cover contention: req_valid_i=4'b1111 held, pointer 0 -> grant order 0,1,2,3,0, each grant following the previous handshake.
REQ-036 SHALL cover backpressure: rsp_ready_i low for 10 cycles -> rsp_valid_o and rsp_crc_o stable, req_ready_o stays 0.
REQ-037 SHALL cover reset mid-operation: reset asserted in WAIT -> next cycle all outputs 0, busy_o=0; a late crc_done_i produces no rsp_valid_o.
REQ-038 SHALL cover timeout (macro on, TIMEOUT_CYCLES=8): no crc_done_i -> rsp_valid_o with rsp_err_o=1, rsp_crc_o=16'h0000 after 8 WAIT cycles; with macro off -> busy_o remains 1.
REQ-039 SHALL cover a spurious done: crc_done_i pulsed in IDLE -> no state change, rsp_valid_o=0.

Source files
------------

// File: rtl/ip_codma_machine_states_pkg.sv
// Shared FSM states, widths and helpers for the CODMA CRC scheduler.
// Imported by the arbiter and the scheduler top.
package ip_codma_machine_states_pkg;

    localparam int CRC_W      = 16;
    localparam int ID_W       = 3;
    localparam int DATA_WORDS = 8;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } crc_state_e;

    typedef logic [DATA_WORDS-1:0][WORD_W-1:0] crc_block_t;

    // Pointer advance with wrap at num requesters.
    function automatic logic [ID_W-1:0] rr_next(
        input logic [ID_W-1:0] id,
        input int              num
    );
        return (int'(id) >= num - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/ip_codma_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer wins.
// Combinational; produces a one-hot grant and the binary index.
module ip_codma_rr_arbiter
    import ip_codma_machine_states_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;

    // Offset k walks from the pointer; i is the requester at that offset.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] &&
                    ((int'(ptr) + k == i) ||
                     (int'(ptr) + k == i + NUM_REQ))) begin
                    grant[i] = 1'b1;
                    idx      = ID_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ip_codma_crc_scheduler.sv
// Shares one CRC engine among NUM_REQ requesters, round-robin, one job at a time.
// Define CODMA_CRC_TIMEOUT_EN to abort a job after TIMEOUT_CYCLES cycles in WAIT.
module ip_codma_crc_scheduler
    import ip_codma_machine_states_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [NUM_REQ-1:0]                        req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WORDS-1:0][WORD_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                        req_ready_o,
    output logic                                      crc_start_o,
    output logic [DATA_WORDS-1:0][WORD_W-1:0]         crc_data_o,
    input  logic                                      crc_done_i,
    input  logic [CRC_W-1:0]                          crc_result_i,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic [ID_W-1:0]                           rsp_id_o,
    output logic [CRC_W-1:0]                          rsp_crc_o,
    output logic                                      rsp_err_o,
    output logic                                      busy_o
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("ip_codma_crc_scheduler: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ip_codma_crc_scheduler: TIMEOUT_CYCLES must be >= 1");
    end

    crc_state_e         state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    crc_block_t         sel_data;

    ip_codma_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_data = req_data_i[i];
        end
    end

`ifdef CODMA_CRC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;

    // Last WAIT cycle is the one where the count reaches TIMEOUT_CYCLES-1.
    assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign rsp_err_o = 1'b0;
`endif

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            req_ready_o <= '0;
            crc_start_o <= 1'b0;
            crc_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_crc_o   <= '0;
`ifdef CODMA_CRC_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            req_ready_o <= '0;
            crc_start_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        req_ready_o <= grant;
                        crc_data_o  <= sel_data;
                        rsp_id_o    <= grant_idx;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    crc_start_o <= 1'b1;
                    state       <= ST_WAIT;
`ifdef CODMA_CRC_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ST_WAIT: begin
                    if (crc_done_i) begin
                        rsp_crc_o   <= crc_result_i;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESPOND;
`ifdef CODMA_CRC_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_crc_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESPOND;
                    end else begin
                        wait_cnt    <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        ptr         <= rr_next(rsp_id_o, NUM_REQ);
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_codma_crc_scheduler.sv
// Scoreboard bench for ip_codma_crc_scheduler: directed stimulus pushes expected
// grants/responses; a negedge monitor pops and compares them.
module tb_ip_codma_crc_scheduler;
    import ip_codma_machine_states_pkg::*;

    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] crc;
        logic        err;
    } rsp_t;

    logic                                           clk_i = 1'b0;
    logic                                           reset_n_i;
    logic [NUM_REQ-1:0]                             req_valid_i;
    logic [NUM_REQ-1:0][DATA_WORDS-1:0][WORD_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]                             req_ready_o;
    logic                                           crc_start_o;
    logic [DATA_WORDS-1:0][WORD_W-1:0]              crc_data_o;
    logic                                           crc_done_i;
    logic [15:0]                                    crc_result_i;
    logic                                           rsp_valid_o;
    logic                                           rsp_ready_i;
    logic [2:0]                                     rsp_id_o;
    logic [15:0]                                    rsp_crc_o;
    logic                                           rsp_err_o;
    logic                                           busy_o;

    int checks = 0;
    int errors = 0;
    int grant_cnt = 0;

    logic [NUM_REQ-1:0] gq[$];
    rsp_t               rq[$];

    bit          eng_en   = 1'b1;
    int          eng_lat  = 2;
    logic        eng_done = 1'b0;
    logic [15:0] eng_res  = '0;
    logic        spur_done = 1'b0;
    logic [15:0] spur_res  = '0;

    assign crc_done_i   = eng_done | spur_done;
    assign crc_result_i = eng_done ? eng_res : spur_res;

    always #5 clk_i = ~clk_i;

    ip_codma_crc_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .crc_start_o  (crc_start_o),
        .crc_data_o   (crc_data_o),
        .crc_done_i   (crc_done_i),
        .crc_result_i (crc_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_crc_o    (rsp_crc_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 32'({|req_ready_o, crc_start_o, |crc_data_o, rsp_valid_o,
                       |rsp_id_o, |rsp_crc_o, rsp_err_o, busy_o}), 32'h0);
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input string name, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (req_ready_o != '0) return;
        end
        chk(name, 32'h0, 32'h1);
    endtask

    task automatic wait_rsp_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rsp_valid_o) return;
        end
        chk(name, 32'h0, 32'h1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (gq.size() == 0 && rq.size() == 0 && !busy_o) return;
        end
        chk(name, 32'(gq.size() + rq.size()), 32'h0);
    endtask

    // Engine model: result = word0[15:0] ^ 16'hA5A5, read at done time.
    initial begin
        forever begin
            @(negedge clk_i);
            if (crc_start_o && eng_en) begin
                repeat (eng_lat) @(posedge clk_i);
                #2;
                eng_done = 1'b1;
                eng_res  = crc_data_o[0][15:0] ^ 16'hA5A5;
                @(posedge clk_i);
                #2;
                eng_done = 1'b0;
                eng_res  = '0;
            end
        end
    end

    // Monitor: compare each grant pulse and each response handshake.
    always @(negedge clk_i) begin
        logic [NUM_REQ-1:0] eg;
        rsp_t               er;
        if (reset_n_i && req_ready_o != '0) begin
            grant_cnt++;
            if (gq.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready_o), 32'h0);
            end else begin
                eg = gq.pop_front();
                chk("grant", 32'(req_ready_o), 32'(eg));
            end
        end
        if (reset_n_i && rsp_valid_o && rsp_ready_i) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                er = rq.pop_front();
                chk("rsp_id", 32'(rsp_id_o), 32'(er.id));
                chk("rsp_crc", 32'(rsp_crc_o), 32'(er.crc));
                chk("rsp_err", 32'(rsp_err_o), 32'(er.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    logic [15:0] cont_crc [5];
    int          cont_id  [5];

    initial begin
        int n;
        int g0;
        bit saw;
        cont_crc = '{16'hB795, 16'hB794, 16'hB797, 16'hB796, 16'hB795};
        cont_id  = '{0, 1, 2, 3, 0};

        reset_n_i   = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        check_all_zero("reset_outputs");
        reset_n_i = 1'b1;
        tick();
        check_all_zero("after_release");

        // Done pulse while idle must not move anything.
        spur_done = 1'b1;
        spur_res  = 16'hBEEF;
        tick();
        spur_done = 1'b0;
        spur_res  = '0;
        tick();
        chk("spurious_busy", 32'(busy_o), 32'h0);
        chk("spurious_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("spurious_rsp_crc", 32'(rsp_crc_o), 32'h0);

        // Single request from requester 2.
        req_data_i[2][0] = 32'h0000_69f2;
        gq.push_back(4'b0100);
        rq.push_back(rsp_t'{id: 3'd2, crc: 16'hCC57, err: 1'b0});
        req_valid_i = 4'b0100;
        wait_grant("single_grant_timeout", n);
        req_valid_i = '0;
        chk("single_grant_latency", 32'(n), 32'd1);
        chk("single_busy", 32'(busy_o), 32'h1);
        tick();
        chk("single_start", 32'(crc_start_o), 32'h1);
        chk("single_ready_pulse", 32'(req_ready_o), 32'h0);
        tick();
        chk("single_start_pulse", 32'(crc_start_o), 32'h0);
        chk("single_data", crc_data_o[0], 32'h0000_69f2);
        wait_drain("single_drain");

        // Contention from pointer 0: grants 0,1,2,3,0.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_i[i][0] = 32'h0000_1230 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            gq.push_back(NUM_REQ'(1) << cont_id[k]);
            rq.push_back(rsp_t'{id: 3'(cont_id[k]), crc: cont_crc[k], err: 1'b0});
        end
        g0 = grant_cnt;
        req_valid_i = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant_cnt >= g0 + 5) break;
        end
        req_valid_i = '0;
        chk("contention_grants", 32'(grant_cnt - g0), 32'd5);
        wait_drain("contention_drain");

        // Backpressure: response held 10 cycles, requester 0 kept waiting.
        rsp_ready_i = 1'b0;
        gq.push_back(4'b0010);
        rq.push_back(rsp_t'{id: 3'd1, crc: 16'hB794, err: 1'b0});
        gq.push_back(4'b0001);
        rq.push_back(rsp_t'{id: 3'd0, crc: 16'hB795, err: 1'b0});
        req_valid_i = 4'b0010;
        wait_grant("bp_grant_timeout", n);
        req_valid_i = 4'b0001;
        wait_rsp_valid("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid_o), 32'h1);
            chk("bp_crc", 32'(rsp_crc_o), 32'hB794);
            chk("bp_id", 32'(rsp_id_o), 32'h1);
            chk("bp_no_grant", 32'(req_ready_o), 32'h0);
        end
        rsp_ready_i = 1'b1;
        wait_grant("bp_next_grant_timeout", n);
        req_valid_i = '0;
        wait_drain("bp_drain");

        // Reset while waiting on the engine; its late done is ignored.
        eng_lat = 6;
        gq.push_back(4'b1000);
        req_valid_i = 4'b1000;
        wait_grant("rst_grant_timeout", n);
        req_valid_i = '0;
        tick();
        chk("rst_in_wait", 32'(crc_start_o), 32'h1);
        reset_n_i = 1'b0;
        tick();
        check_all_zero("reset_mid_job");
        reset_n_i = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid_o || busy_o) saw = 1'b1;
        end
        chk("late_done_ignored", 32'(saw), 32'h0);
        eng_lat = 2;

        // No engine completion.
        eng_en = 1'b0;
        gq.push_back(4'b0100);
`ifdef CODMA_CRC_TIMEOUT_EN
        rq.push_back(rsp_t'{id: 3'd2, crc: 16'h0000, err: 1'b1});
`endif
        req_valid_i = 4'b0100;
        wait_grant("to_grant_timeout", n);
        req_valid_i = '0;
        tick();
        chk("to_start", 32'(crc_start_o), 32'h1);
`ifdef CODMA_CRC_TIMEOUT_EN
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'd8);
        chk("to_err", 32'(rsp_err_o), 32'h1);
        chk("to_crc", 32'(rsp_crc_o), 32'h0);
        wait_drain("to_drain");
`else
        repeat (30) tick();
        chk("no_to_busy", 32'(busy_o), 32'h1);
        chk("no_to_rsp_valid", 32'(rsp_valid_o), 32'h0);
        apply_reset();
`endif
        eng_en = 1'b1;

        tick();
        chk("queues_drained", 32'(gq.size() + rq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
